// File: rtl/if_pkg.sv
// Shared fetch-side types and constants: FSM states, redirect sources and the
// reset/exception vectors (CP0 uses the same vectors).
package if_pkg;

    localparam logic [31:0] RESET_PC  = 32'hBFC0_0000;
    localparam logic [31:0] EX_VECTOR = 32'hBFC0_0380;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        FULL
    } fetch_state_e;

    typedef enum logic [1:0] {
        RS_NONE,
        RS_BR,
        RS_ERET,
        RS_EX
    } redir_src_e;

    // ex/eret are pipeline flushes; they outrank a branch held in the pending slot.
    function automatic logic is_flush(input redir_src_e src);
        return (src == RS_ERET) || (src == RS_EX);
    endfunction

endpackage

// File: rtl/redirect_pick.sv
// Priority select of the redirect source plus the pending target/source register
// that remembers where to go once a stale fetch has drained.
module redirect_pick
    import if_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        ex_valid,
    input  logic        eret_valid,
    input  logic [31:0] epc,
    input  logic        br_valid,
    input  logic [31:0] br_target,
    input  logic        capture,
    input  logic        clear,
    output logic        redirect,
    output logic [31:0] target,
    output logic        pending_valid,
    output logic [31:0] pending_target,
    output logic [31:0] resolved_target
);

    redir_src_e  src;
    redir_src_e  pend_src_q, pend_src_d;
    logic [31:0] pend_target_q, pend_target_d;
    logic        take;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        src           = RS_NONE;
        target        = br_target;
        pend_src_d    = pend_src_q;
        pend_target_d = pend_target_q;

        if (ex_valid) begin
            src    = RS_EX;
            target = EX_VECTOR;
        end else if (eret_valid) begin
            src    = RS_ERET;
            target = epc + 32'd4;
        end else if (br_valid) begin
            src    = RS_BR;
        end

        redirect        = (src != RS_NONE);
        // A branch cannot displace a flush target that is already waiting.
        take            = is_flush(src) || ((src == RS_BR) && !is_flush(pend_src_q));
        resolved_target = take ? target : pend_target_q;

        if (clear) begin
            pend_src_d    = RS_NONE;
            pend_target_d = 32'h0;
        end else if (capture && take) begin
            pend_src_d    = src;
            pend_target_d = target;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!resetn) begin
            pend_src_q    <= RS_NONE;
            pend_target_q <= 32'h0;
        end else begin
            pend_src_q    <= pend_src_d;
            pend_target_q <= pend_target_d;
        end
    end

    assign pending_valid  = (pend_src_q != RS_NONE);
    assign pending_target = pend_target_q;

endmodule

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, keeps one request in flight,
// drops responses made stale by a redirect and buffers one instruction for ID.
module if_fetch_ctrl
    import if_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        ex_valid,
    input  logic        eret_valid,
    input  logic [31:0] epc,
    input  logic        br_valid,
    input  logic [31:0] br_target,
    input  logic        id_allowin,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst
);

    fetch_state_e state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic         if_valid_q, if_valid_d;
    logic [31:0]  if_pc_q, if_pc_d;
    logic [31:0]  if_inst_q, if_inst_d;

    logic         redirect;
    logic [31:0]  target;
    logic         discard;
    logic [31:0]  pending_target;
    logic [31:0]  resolved_target;
    logic         capture;
    logic         clear;

    redirect_pick u_redirect_pick (
        .clk             (clk),
        .resetn          (resetn),
        .ex_valid        (ex_valid),
        .eret_valid      (eret_valid),
        .epc             (epc),
        .br_valid        (br_valid),
        .br_target       (br_target),
        .capture         (capture),
        .clear           (clear),
        .redirect        (redirect),
        .target          (target),
        .pending_valid   (discard),
        .pending_target  (pending_target),
        .resolved_target (resolved_target)
    );

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        if_valid_d = if_valid_q;
        if_pc_d    = if_pc_q;
        if_inst_d  = if_inst_q;
        capture    = 1'b0;
        clear      = 1'b0;
        inst_req   = 1'b0;

        case (state_q)
            IDLE: begin
                state_d = REQ;
                if (redirect) fetch_pc_d = target;
            end
            REQ: begin
                // The address is already on the bus, so a redirect only marks it stale.
                inst_req = 1'b1;
                capture  = redirect;
                if (inst_addr_ok) state_d = WAIT;
            end
            WAIT: begin
                if (inst_data_ok) begin
                    clear   = 1'b1;
                    state_d = REQ;
                    if (discard || redirect) begin
                        fetch_pc_d = resolved_target;
                    end else begin
                        if_valid_d = 1'b1;
                        if_pc_d    = fetch_pc_q;
                        if_inst_d  = inst_rdata;
                        fetch_pc_d = fetch_pc_q + 32'd4;
                        state_d    = FULL;
                    end
                end else begin
                    capture = redirect;
                end
            end
            FULL: begin
                if (redirect) begin
                    if_valid_d = 1'b0;
                    fetch_pc_d = target;
                    state_d    = REQ;
                end else if (id_allowin) begin
                    if_valid_d = 1'b0;
                    state_d    = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            if_valid_q <= 1'b0;
            if_pc_q    <= 32'h0;
            if_inst_q  <= 32'h0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            if_valid_q <= if_valid_d;
            if_pc_q    <= if_pc_d;
            if_inst_q  <= if_inst_d;
        end
    end

    assign inst_addr = fetch_pc_q;
    assign if_valid  = if_valid_q;
    assign if_pc     = if_pc_q;
    assign if_inst   = if_inst_q;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Self-checking bench for if_fetch_ctrl: directed scenarios then random redirects,
// stalls and memory latencies against a transaction-level fetch model.
module tb_if_fetch_ctrl;
    import if_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ex_valid, eret_valid, br_valid, id_allowin;
    logic [31:0] epc, br_target;
    logic        inst_req, inst_addr_ok, inst_data_ok;
    logic [31:0] inst_addr, inst_rdata;
    logic        if_valid;
    logic [31:0] if_pc, if_inst;

    always #5 clk = ~clk;

    if_fetch_ctrl dut (
        .clk          (clk),
        .resetn       (resetn),
        .ex_valid     (ex_valid),
        .eret_valid   (eret_valid),
        .epc          (epc),
        .br_valid     (br_valid),
        .br_target    (br_target),
        .id_allowin   (id_allowin),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .if_valid     (if_valid),
        .if_pc        (if_pc),
        .if_inst      (if_inst)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: a fetch is either being fetched, held for ID, or just out of reset.
    typedef enum {P_BOOT, P_FETCH, P_HOLD} phase_e;
    phase_e      ph;
    logic [31:0] m_pc;
    bit          m_out_v;
    logic [31:0] m_out_pc, m_out_inst;
    bit          m_stale;
    bit          m_pend_flush;
    logic [31:0] m_pend;

    // Memory model: one accepted read, returned after mem_cnt idle cycles.
    bit          mem_busy;
    logic [31:0] mem_addr;
    int          mem_cnt;
    bit          addr_rand;
    int          mem_lat;

    function automatic logic [31:0] rdata_of(input logic [31:0] a);
        return {a[15:0] ^ 16'hA5C3, a[31:16]};
    endfunction

    function automatic bit in_state(input int k);
        case (k)
            0:       return (ph == P_FETCH) && !mem_busy;
            1:       return (ph == P_FETCH) && mem_busy;
            default: return ph == P_HOLD;
        endcase
    endfunction

    task automatic model_reset();
        ph           = P_BOOT;
        m_pc         = RESET_PC;
        m_out_v      = 1'b0;
        m_stale      = 1'b0;
        m_pend_flush = 1'b0;
        m_pend       = 32'h0;
        mem_busy     = 1'b0;
    endtask

    // Called at a negedge: check outputs, drive one cycle, advance the model.
    task automatic step(input bit ex, input bit er, input logic [31:0] ep, input bit br,
                        input logic [31:0] bt, input bit allow, input bit spur);
        bit          r, fl, dev, req_s;
        logic [31:0] t, addr_s;
        check("if_valid", {31'h0, if_valid}, {31'h0, m_out_v});
        if (m_out_v) begin
            check("if_pc", if_pc, m_out_pc);
            check("if_inst", if_inst, m_out_inst);
        end
        check("inst_req", {31'h0, inst_req}, {31'h0, in_state(0)});
        if (in_state(0)) check("inst_addr", inst_addr, m_pc);
        req_s  = inst_req;
        addr_s = inst_addr;

        ex_valid     = ex;
        eret_valid   = er;
        epc          = ep;
        br_valid     = br;
        br_target    = bt;
        id_allowin   = allow;
        inst_addr_ok = req_s && !mem_busy && (!addr_rand || ($urandom_range(0, 2) != 0));
        inst_data_ok = mem_busy && (mem_cnt == 0);
        inst_rdata   = inst_data_ok ? rdata_of(mem_addr) : 32'hDEAD_BEEF;
        if (!mem_busy && spur) begin
            inst_data_ok = 1'b1;
            inst_rdata   = $urandom;
        end

        @(posedge clk);
        r   = ex || er || br;
        fl  = ex || er;
        t   = ex ? EX_VECTOR : (er ? ep + 32'd4 : bt);
        dev = mem_busy && inst_data_ok;
        case (ph)
            P_BOOT: begin
                if (r) m_pc = t;
                ph = P_FETCH;
            end
            P_HOLD: begin
                if (r) begin
                    m_out_v = 1'b0;
                    m_pc    = t;
                    ph      = P_FETCH;
                end else if (allow) begin
                    m_out_v = 1'b0;
                    ph      = P_FETCH;
                end
            end
            default: begin
                if (r && (fl || !(m_stale && m_pend_flush))) begin
                    m_pend       = t;
                    m_pend_flush = fl;
                end
                if (r) m_stale = 1'b1;
                if (dev) begin
                    if (m_stale) begin
                        m_pc         = m_pend;
                        m_stale      = 1'b0;
                        m_pend_flush = 1'b0;
                    end else begin
                        m_out_v    = 1'b1;
                        m_out_pc   = m_pc;
                        m_out_inst = rdata_of(m_pc);
                        m_pc       = m_pc + 32'd4;
                        ph         = P_HOLD;
                    end
                end
            end
        endcase

        if (dev) mem_busy = 1'b0;
        else if (mem_busy) mem_cnt--;
        if (req_s && inst_addr_ok) begin
            mem_busy = 1'b1;
            mem_addr = addr_s;
            mem_cnt  = addr_rand ? $urandom_range(0, 2) : mem_lat;
        end
        @(negedge clk);
    endtask

    task automatic idle_step(input bit allow);
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, allow, 1'b0);
    endtask

    task automatic go(input int k);
        for (int i = 0; i < 40 && !in_state(k); i++) idle_step(1'b1);
        check("reach_state", {31'h0, in_state(k)}, 32'h1);
    endtask

    task automatic do_reset();
        resetn       = 1'b0;
        ex_valid     = 1'b0;
        eret_valid   = 1'b0;
        br_valid     = 1'b0;
        epc          = 32'h0;
        br_target    = 32'h0;
        id_allowin   = 1'b0;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        inst_rdata   = 32'h0;
        @(negedge clk);
        check("rst_req", {31'h0, inst_req}, 32'h0);
        check("rst_valid", {31'h0, if_valid}, 32'h0);
        check("rst_pc", if_pc, 32'h0);
        check("rst_inst", if_inst, 32'h0);
        check("rst_addr", inst_addr, RESET_PC);
        @(negedge clk);
        resetn = 1'b1;
        model_reset();
    endtask

    logic [31:0] saved;

    initial begin
        addr_rand = 1'b0;
        mem_lat   = 0;
        do_reset();

        // Zero-wait memory, ID always ready: three sequential instructions.
        for (int k = 0; k < 3; k++) begin
            go(2);
            check("seq_pc", if_pc, RESET_PC + 32'(4 * k));
            check("seq_inst", if_inst, rdata_of(RESET_PC + 32'(4 * k)));
            idle_step(1'b1);
        end

        // ID stalls for 5 cycles while holding an instruction.
        go(2);
        saved = if_pc;
        for (int k = 0; k < 5; k++) begin
            idle_step(1'b0);
            check("stall_valid", {31'h0, if_valid}, 32'h1);
            check("stall_pc", if_pc, saved);
            check("stall_req", {31'h0, inst_req}, 32'h0);
        end
        idle_step(1'b1);
        check("stall_next_req", {31'h0, inst_req}, 32'h1);
        check("stall_next_addr", inst_addr, saved + 32'd4);

        // Branch while the read is in flight: stale data dropped.
        mem_lat = 2;
        go(1);
        step(1'b0, 1'b0, 32'h0, 1'b1, 32'h8000_1000, 1'b1, 1'b0);
        go(0);
        check("br_wait_valid", {31'h0, if_valid}, 32'h0);
        check("br_wait_addr", inst_addr, 32'h8000_1000);

        // ex and br together while FULL: exception wins.
        mem_lat = 0;
        go(2);
        step(1'b1, 1'b0, 32'h0, 1'b1, 32'h8000_2000, 1'b0, 1'b0);
        check("ex_br_valid", {31'h0, if_valid}, 32'h0);
        check("ex_br_addr", inst_addr, EX_VECTOR);

        // eret in REQ, then a branch before data_ok: the branch is ignored.
        mem_lat = 2;
        go(0);
        step(1'b0, 1'b1, 32'h8000_0010, 1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 32'h8000_3000, 1'b1, 1'b0);
        go(0);
        check("eret_br_addr", inst_addr, 32'h8000_0014);

        // Sequential fetch across the top of the address space.
        mem_lat = 0;
        go(2);
        step(1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
        go(2);
        check("wrap_pc", if_pc, 32'hFFFF_FFFC);
        idle_step(1'b1);
        check("wrap_addr", inst_addr, 32'h0000_0000);

        // Reset asserted while a read is outstanding.
        mem_lat = 2;
        go(1);
        #2 resetn = 1'b0;
        #1;
        check("midrst_req", {31'h0, inst_req}, 32'h0);
        check("midrst_valid", {31'h0, if_valid}, 32'h0);
        do_reset();
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
        go(0);
        check("restart_addr", inst_addr, RESET_PC);

        // Random redirects, stalls, latencies and stray data_ok pulses.
        addr_rand = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 39) == 0,
                 $urandom_range(0, 29) == 0, {$urandom} & 32'hFFFF_FFFC,
                 $urandom_range(0, 11) == 0, {$urandom} & 32'hFFFF_FFFC,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 7) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
